// File: rtl/skinny_sbox_serial_ctrl.sv
// Serial two-share driver for the masked Skinny-64 S-box: one nibble per SBOX_LAT cycles.
// Optional macro FRESH_LFSR_EN sources fresh randomness from an internal 16-bit LFSR instead of rand_in.
module skinny_sbox_serial_ctrl #(
  parameter int unsigned SBOX_LAT  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] st_s0,
  input  logic [63:0] st_s1,
  output logic        busy,
  output logic        done,
  output logic [63:0] res_s0,
  output logic [63:0] res_s1,
  output logic [3:0]  sb_x_s0,
  output logic [3:0]  sb_x_s1,
  output logic [3:0]  sb_fresh,
  input  logic [3:0]  sb_y_s0,
  input  logic [3:0]  sb_y_s1,
  input  logic [3:0]  rand_in
);

  localparam int unsigned   P_W    = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(SBOX_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [3:0]     n_r, n_s;
  logic [P_W-1:0] p_r, p_s;
  logic [63:0]    in_s0_r, in_s0_s, in_s1_r, in_s1_s;
  logic [63:0]    res_s0_r, res_s0_s, res_s1_r, res_s1_s;
  logic [3:0]     fresh_r, fresh_s;
  logic [3:0]     sb_x_s0_r, sb_x_s0_s, sb_x_s1_r, sb_x_s1_s;
  logic           busy_r, busy_s, done_r, done_s;
  logic           nib_start_s;
  logic [3:0]     fresh_src_s;
  logic           unused_s;

`ifdef FRESH_LFSR_EN
  logic [15:0] lfsr_r, lfsr_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign fresh_src_s = lfsr_r[3:0];
  assign unused_s    = ^rand_in;

  // LFSR next value: steps only when a nibble starts
  always_comb begin
    lfsr_s = lfsr_r;
    if (nib_start_s) begin
      lfsr_s = lfsr_step(lfsr_r);
    end else begin
      lfsr_s = lfsr_r;
    end
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_s;
    end
  end
`else
  assign fresh_src_s = rand_in;
  assign unused_s    = ^LFSR_SEED;
`endif

  // Next-state, counters, capture and next output values
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    p_s         = p_r;
    in_s0_s     = in_s0_r;
    in_s1_s     = in_s1_r;
    res_s0_s    = res_s0_r;
    res_s1_s    = res_s1_r;
    nib_start_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = RUN;
          in_s0_s     = st_s0;
          in_s1_s     = st_s1;
          n_s         = 4'd0;
          p_s         = '0;
          nib_start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (p_r == P_LAST) begin
          res_s0_s[{n_r, 2'b00} +: 4] = sb_y_s0;
          res_s1_s[{n_r, 2'b00} +: 4] = sb_y_s1;
          p_s = '0;
          if (n_r == 4'd15) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            n_s         = n_r + 4'd1;
            nib_start_s = 1'b1;
          end
        end else begin
          p_s = p_r + {{(P_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Fresh value is held per nibble and cleared on leaving RUN so sb_fresh reads 0 outside it
    fresh_s = fresh_r;
    if (nib_start_s) begin
      fresh_s = fresh_src_s;
    end else if (state_s != RUN) begin
      fresh_s = 4'd0;
    end else begin
      fresh_s = fresh_r;
    end

    busy_s = (state_s == RUN);
    if (state_s == RUN) begin
      sb_x_s0_s = in_s0_s[{n_s, 2'b00} +: 4];
      sb_x_s1_s = in_s1_s[{n_s, 2'b00} +: 4];
    end else begin
      sb_x_s0_s = 4'd0;
      sb_x_s1_s = 4'd0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      n_r       <= 4'd0;
      p_r       <= '0;
      in_s0_r   <= 64'd0;
      in_s1_r   <= 64'd0;
      res_s0_r  <= 64'd0;
      res_s1_r  <= 64'd0;
      fresh_r   <= 4'd0;
      sb_x_s0_r <= 4'd0;
      sb_x_s1_r <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      n_r       <= n_s;
      p_r       <= p_s;
      in_s0_r   <= in_s0_s;
      in_s1_r   <= in_s1_s;
      res_s0_r  <= res_s0_s;
      res_s1_r  <= res_s1_s;
      fresh_r   <= fresh_s;
      sb_x_s0_r <= sb_x_s0_s;
      sb_x_s1_r <= sb_x_s1_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign res_s0   = res_s0_r;
  assign res_s1   = res_s1_r;
  assign sb_x_s0  = sb_x_s0_r;
  assign sb_x_s1  = sb_x_s1_r;
  assign sb_fresh = fresh_r;

endmodule

// File: tb/tb_skinny_sbox_serial_ctrl.sv
// Bench for skinny_sbox_serial_ctrl: behavioural masked S-box with latency LAT-1 and a pass-level reference.
module tb_skinny_sbox_serial_ctrl;
  localparam int LAT = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int NCYC = 16 * LAT + 1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] st_s0, st_s1;
  logic        busy, done;
  logic [63:0] res_s0, res_s1;
  logic [3:0]  sb_x_s0, sb_x_s1, sb_fresh, sb_y_s0, sb_y_s1, rand_in;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] old0, old1;
  logic [15:0] lfsr_m;

  skinny_sbox_serial_ctrl #(.SBOX_LAT(LAT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .st_s0(st_s0), .st_s1(st_s1),
    .busy(busy), .done(done), .res_s0(res_s0), .res_s1(res_s1),
    .sb_x_s0(sb_x_s0), .sb_x_s1(sb_x_s1), .sb_fresh(sb_fresh),
    .sb_y_s0(sb_y_s0), .sb_y_s1(sb_y_s1), .rand_in(rand_in)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hF7E4D583B2A1096C;
    return t[4*x +: 4];
  endfunction

  // Behavioural S-box: output reflects the input shares from LAT-1 cycles earlier
  logic [3:0] d0 [LAT-1];
  logic [3:0] d1 [LAT-1];
  always @(posedge clk) begin
    d0[0] <= sb_x_s0;
    d1[0] <= sb_x_s1;
    for (int i = 1; i < LAT - 1; i++) begin
      d0[i] <= d0[i-1];
      d1[i] <= d1[i-1];
    end
  end
  assign sb_y_s1 = d1[LAT-2];
  assign sb_y_s0 = sbox(d0[LAT-2] ^ d1[LAT-2]) ^ d1[LAT-2];

  task automatic get_fresh(output logic [3:0] f);
`ifdef FRESH_LFSR_EN
    f = lfsr_m[3:0];
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
    f = rand_in;
`endif
  endtask

  task automatic run_pass(input logic [63:0] s0, input logic [63:0] s1, input bit noise,
                          input bit tail_idle, input int abort_at);
    logic [3:0]  fr [16];
    logic [63:0] new0, new1, e0, e1;
    logic [14:0] ectl, actl;
    int c;
    bit aborted;
    aborted = 1'b0;
    new1 = s1;
    for (int i = 0; i < 16; i++) new0[4*i +: 4] = sbox(s0[4*i +: 4] ^ s1[4*i +: 4]) ^ s1[4*i +: 4];
    @(negedge clk);
    start = 1'b1; st_s0 = s0; st_s1 = s1; rand_in = 4'($urandom);
    get_fresh(fr[0]);
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      c = (k - 1) / LAT;
      for (int i = 0; i < 16; i++) begin
        e0[4*i +: 4] = (i < c) ? new0[4*i +: 4] : old0[4*i +: 4];
        e1[4*i +: 4] = (i < c) ? new1[4*i +: 4] : old1[4*i +: 4];
      end
      if (k < NCYC) ectl = {1'b1, 1'b0, s0[4*c +: 4], s1[4*c +: 4], fr[c]};
      else          ectl = {1'b0, 1'b1, 12'd0};
      actl = {busy, done, sb_x_s0, sb_x_s1, sb_fresh};
      vectors++;
      if (actl !== ectl) begin
        miscompares++;
        $display("FAIL ctrl cycle %0d: {busy,done,x0,x1,fresh} got %h want %h", k, actl, ectl);
      end
      vectors++;
      if ({res_s0, res_s1} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL res cycle %0d: got %h/%h want %h/%h", k, res_s0, res_s1, e0, e1);
      end
      start = noise && (k == 10 || k == NCYC);
      st_s0 = {$urandom, $urandom};
      st_s1 = {$urandom, $urandom};
      rand_in = 4'($urandom);
      if (k % LAT == 0 && k / LAT <= 15) get_fresh(fr[k / LAT]);
      if (k == abort_at) begin
        rst = 1'b1; start = 1'b0; aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      old0 = new0; old1 = new1;
    end
    if (tail_idle) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL ignored_start: {busy,done} got %b want 00", {busy, done});
      end
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; st_s0 = 64'd0; st_s1 = 64'd0; rand_in = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, res_s0, res_s1, sb_x_s0, sb_x_s1, sb_fresh} !== 142'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b res=%h/%h x=%h/%h fresh=%h want all 0",
               busy, done, res_s0, res_s1, sb_x_s0, sb_x_s1, sb_fresh);
    end
    rst = 1'b0; old0 = 64'd0; old1 = 64'd0; lfsr_m = SEED;
  endtask

  task automatic test_unmasked;
    run_pass(64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0, 0);
    vectors++;
    if ((res_s0 ^ res_s1) !== 64'hC6901A2B385D4E7F) begin
      miscompares++;
      $display("FAIL unmasked: got %h want C6901A2B385D4E7F", res_s0 ^ res_s1);
    end
  endtask

  task automatic test_masked;
    logic [63:0] m;
    m = 64'hA5A5_5A5A_F00F_1234;
    run_pass(64'h0123456789ABCDEF ^ m, m, 1'b0, 1'b0, 0);
    vectors++;
    if ((res_s0 ^ res_s1) !== 64'hC6901A2B385D4E7F || res_s0 === 64'hC6901A2B385D4E7F
        || res_s1 === 64'hC6901A2B385D4E7F) begin
      miscompares++;
      $display("FAIL masked: got %h^%h want recombined C6901A2B385D4E7F, shares masked", res_s0, res_s1);
    end
  endtask

  task automatic test_ignored_start;
    run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 0);
  endtask

  task automatic test_reset_abort;
    run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 30);
    @(negedge clk);
    vectors++;
    if ({busy, done, res_s0, res_s1, sb_x_s0, sb_x_s1, sb_fresh} !== 142'd0) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b res=%h/%h x=%h/%h fresh=%h want all 0",
               busy, done, res_s0, res_s1, sb_x_s0, sb_x_s1, sb_fresh);
    end
    rst = 1'b0; old0 = 64'd0; old1 = 64'd0; lfsr_m = SEED;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_idle cycle %0d: {busy,done} got %b want 00", k, {busy, done});
      end
    end
    run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 0);
    run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int j = 0; j < 3; j++) begin
      run_pass({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_unmasked();
    test_masked();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
